pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Sequences the enables and flushes of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline buffers and the PC.
//  Handles three cases: load-use stalls, branch/jump squashes, and multi-cycle data-memory waits (req/ready).
//  Drives a timeout error if memory never answers, and keeps a saturating stall-cycle counter.
//  Sits beside the datapath; its outputs gate every pipeline buffer's load and its bubble (zero) input.
// PARAMETERS
//  MEM_TIMEOUT  64  max cycles in MEM_WAIT before HALT_ERR (>=2)
//  CNT_W        16  width of stall_cycles counter
// PORTS
//  clk           in   1      clock; all state updates on posedge clk
//  reset         in   1      synchronous, active-high
//  ifid_rs       in   5      rs field of the instruction in ID
//  ifid_rt       in   5      rt field of the instruction in ID
//  ifid_uses_rt  in   1      the instruction in ID reads rt (R-type/store/branch)
//  idex_MemRead  in   1      the instruction in EX is a load
//  idex_rt       in   5      destination rt of the load in EX
//  jump_id       in   1      jump decoded in ID
//  branch_taken  in   1      branch resolved taken in EX
//  exmem_MemRead in   1      the instruction in MEM is a load
//  exmem_MemWrite in  1      the instruction in MEM is a store
//  dmem_ready    in   1      data memory completes the access this cycle
//  dmem_req      out  1      data-memory access request
//  pc_en         out  1      PC load enable
//  ifid_en       out  1      IF/ID load enable
//  ifid_flush    out  1      IF/ID loads zeros
//  idex_en       out  1      ID/EX load enable
//  idex_flush    out  1      ID/EX loads zeros (bubble)
//  exmem_en      out  1      EX/MEM load enable
//  memwb_en      out  1      MEM/WB load enable
//  memwb_bubble  out  1      MEM/WB loads zeros (RegWrite=0)
//  timeout_err   out  1      sticky error; set in HALT_ERR
//  stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 in RUN/MEM_WAIT
// BEHAVIOUR
//  Clock and reset
//  - Clock is clk; reset is synchronous and active-high.
//  - Outputs are combinational from the FSM state and the current inputs; the state, wait counter and stall_cycles are registered.
//  Reset
//  - While reset=1, regardless of state: pc_en=ifid_en=idex_en=exmem_en=memwb_en=0; ifid_flush=idex_flush=memwb_bubble=1; dmem_req=0; timeout_err=0.
//  - On the next edge: state<=RST_FLUSH, wait_cnt<=0, stall_cycles<=0.
//  - Reset asserted during MEM_WAIT abandons the access: dmem_req drops in that same cycle.
//  FSM states
//  - RST_FLUSH: one cycle. Every buffer is enabled and flushed; pc_en=0. Next state: RUN.
//  - RUN (priority high to low):
//    a) mem = exmem_MemRead|exmem_MemWrite. dmem_req=mem.
//       If mem & !dmem_ready: freeze with pc/ifid/idex/exmem_en=0, memwb_en=1, memwb_bubble=1; next state MEM_WAIT, wait_cnt<=1.
//       If mem & dmem_ready: zero-wait; continue with b)-d).
//    b) branch_taken: pc_en=1, ifid_flush=1, idex_flush=1. Any load-use condition is ignored because the ID instruction is squashed.
//    c) load-use = idex_MemRead & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)):
//       pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. Exactly one bubble; no state change.
//    d) jump_id: pc_en=1, ifid_flush=1.
//    e) Otherwise all enables are 1 and all flushes are 0.
//  - MEM_WAIT: dmem_req=1. Freeze outputs as in a).
//    - dmem_ready=1: all enables 1, memwb_bubble=0 (MEM/WB captures the data); next state RUN.
//    - Otherwise wait_cnt++. When wait_cnt==MEM_TIMEOUT with no ready: next state HALT_ERR.
//    - Branch/jump/load-use inputs are ignored while frozen; they are re-evaluated in RUN.
//  - HALT_ERR: all enables 0, memwb_bubble=1, dmem_req=0, timeout_err=1. Exited only by reset.
//  stall_cycles
//  - Increments on each cycle with pc_en=0 in RUN or MEM_WAIT. Saturates at 2^CNT_W-1; no wrap.
// STRUCTURE
//  - definitions.vh gains the state encodings (`ST_RST_FLUSH, `ST_RUN, `ST_MEM_WAIT, `ST_HALT_ERR, 2 bits) and `MEM_TIMEOUT_DEF.
//  - One sub-module: load_use_detect, purely combinational (hazard compare); the FSM and counters stay in the top.
// TESTING
//  - Reset held 3 cycles then released: cycle 1 RST_FLUSH (pc_en=0, all flushes=1); cycle 2 RUN with all enables=1.
//  - idex_MemRead=1, idex_rt=8, ifid_rs=8: exactly one cycle of pc_en=0, idex_flush=1; stall_cycles=1.
//    Repeat with idex_rt=0: no stall.
//  - branch_taken=1 together with load-use on rt=9: pc_en=1, ifid_flush=idex_flush=1, no stall.
//  - exmem_MemRead=1, dmem_ready low 3 cycles then high: freeze for 3 cycles with memwb_bubble=1;
//    4th cycle all enables=1, memwb_bubble=0; stall_cycles=3.
//  - Store with dmem_ready never asserted, MEM_TIMEOUT=4: HALT_ERR after 4 wait cycles, timeout_err=1 sticky until reset.
//  - Reset asserted on the 2nd MEM_WAIT cycle: dmem_req=0 that cycle; RST_FLUSH next; wait_cnt and stall_cycles cleared.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall controller: FSM encoding and the
// bundle of buffer-control outputs, plus the canned output patterns.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST_FLUSH = 2'd0,
        ST_RUN       = 2'd1,
        ST_MEM_WAIT  = 2'd2,
        ST_HALT_ERR  = 2'd3
    } state_t;

    localparam int MEM_TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF       = 16;

    typedef struct packed {
        logic dmem_req;
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
        logic memwb_bubble;
        logic timeout_err;
    } ctrl_t;

    //                                  req pc  ifid fl  idex fl  ex  mw  bub err
    localparam ctrl_t CTRL_RESET  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};
    localparam ctrl_t CTRL_FLUSH  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0};
    localparam ctrl_t CTRL_RUN    = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0};
    localparam ctrl_t CTRL_FREEZE = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
    localparam ctrl_t CTRL_HALT   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};

endpackage

// File: rtl/pipeline_stall_ctrl_load_use.sv
// Load-use hazard compare: the load in EX writes a register the ID
// instruction is about to read. r0 never creates a dependency.
module load_use_detect (
    input  logic       idex_MemRead,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    output logic       hazard
);
    assign hazard = idex_MemRead && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline enable/flush sequencer: load-use bubbles, branch/jump squashes,
// data-memory wait freezes with timeout, and a saturating stall counter.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_MemRead,
    input  logic [4:0]       idex_rt,
    input  logic             jump_id,
    input  logic             branch_taken,
    input  logic             exmem_MemRead,
    input  logic             exmem_MemWrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             memwb_bubble,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    ctrl_t             ctrl;
    logic              mem, hazard, stall_inc;

    assign mem = exmem_MemRead || exmem_MemWrite;

    load_use_detect u_lud (
        .idex_MemRead (idex_MemRead),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .hazard       (hazard)
    );

    // Stalls are only counted while the pipeline is live, not while flushing or halted.
    assign stall_inc = !ctrl.pc_en && ((state == ST_RUN) || (state == ST_MEM_WAIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RST_FLUSH;
            wait_cnt     <= '0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (stall_inc && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            ST_RST_FLUSH: begin
                state_nxt = ST_RUN;
                wait_nxt  = '0;
            end
            ST_RUN: if (mem && !dmem_ready) begin
                state_nxt = ST_MEM_WAIT;
                wait_nxt  = WAIT_W'(1);
            end
            ST_MEM_WAIT: begin
                if (dmem_ready)              state_nxt = ST_RUN;
                else if (wait_cnt == WAIT_MAX) state_nxt = ST_HALT_ERR;
                else                         wait_nxt  = wait_cnt + 1'b1;
            end
            default: state_nxt = ST_HALT_ERR;
        endcase
    end

    always_comb begin
        ctrl = CTRL_RUN;
        if (reset) begin
            ctrl = CTRL_RESET;
        end else begin
            case (state)
                ST_RST_FLUSH: ctrl = CTRL_FLUSH;
                ST_RUN: begin
                    if (mem && !dmem_ready) begin
                        ctrl = CTRL_FREEZE;
                    end else begin
                        ctrl.dmem_req = mem;
                        // A taken branch squashes ID, so a load-use there is moot.
                        if (branch_taken) begin
                            ctrl.ifid_flush = 1'b1;
                            ctrl.idex_flush = 1'b1;
                        end else if (hazard) begin
                            ctrl.pc_en      = 1'b0;
                            ctrl.ifid_en    = 1'b0;
                            ctrl.idex_flush = 1'b1;
                        end else if (jump_id) begin
                            ctrl.ifid_flush = 1'b1;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        ctrl          = CTRL_RUN;
                        ctrl.dmem_req = 1'b1;
                    end else begin
                        ctrl = CTRL_FREEZE;
                    end
                end
                default: ctrl = CTRL_HALT;
            endcase
        end
    end

    assign dmem_req     = ctrl.dmem_req;
    assign pc_en        = ctrl.pc_en;
    assign ifid_en      = ctrl.ifid_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_en      = ctrl.idex_en;
    assign idex_flush   = ctrl.idex_flush;
    assign exmem_en     = ctrl.exmem_en;
    assign memwb_en     = ctrl.memwb_en;
    assign memwb_bubble = ctrl.memwb_bubble;
    assign timeout_err  = ctrl.timeout_err;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed-vector bench: the driver queues hand-computed expectations, a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_pipeline_stall_ctrl;
    localparam int CNT_W = 3;

    // Output vector order: req pc ifid ifid_fl idex idex_fl exmem memwb bubble err
    localparam logic [9:0] E_RESET  = 10'b0001010010;
    localparam logic [9:0] E_FLUSH  = 10'b0011111110;
    localparam logic [9:0] E_RUN    = 10'b0110101100;
    localparam logic [9:0] E_LU     = 10'b0000111100;
    localparam logic [9:0] E_BR     = 10'b0111111100;
    localparam logic [9:0] E_JMP    = 10'b0111101100;
    localparam logic [9:0] E_FRZ    = 10'b1000000110;
    localparam logic [9:0] E_MEMOK  = 10'b1110101100;
    localparam logic [9:0] E_HALT   = 10'b0000000011;

    typedef struct {
        string            name;
        logic [9:0]       ctl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
    logic ifid_uses_rt = 0, idex_MemRead = 0, jump_id = 0, branch_taken = 0;
    logic exmem_MemRead = 0, exmem_MemWrite = 0, dmem_ready = 0;
    logic dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, memwb_en, memwb_bubble, timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [9:0] act;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_MemRead(idex_MemRead), .idex_rt(idex_rt),
        .jump_id(jump_id), .branch_taken(branch_taken),
        .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req), .pc_en(pc_en),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .memwb_bubble(memwb_bubble), .timeout_err(timeout_err),
        .stall_cycles(stall_cycles)
    );

    assign act = {dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                  exmem_en, memwb_en, memwb_bubble, timeout_err};

    // Monitor: every cycle presents a control word; compare on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (act === e.ctl && stall_cycles === e.cnt) n_pass++;
            else $display("FAIL %s: ctl=%b stall=%0d, expected ctl=%b stall=%0d",
                          e.name, act, stall_cycles, e.ctl, e.cnt);
        end
    end

    // Inputs: {reset, MemRead, idex_rt, rs, rt, uses_rt, branch, jump, exRd, exWr, ready}
    task automatic step(input string name, input logic rst, input logic mr,
                        input logic [4:0] irt, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic br, input logic jp,
                        input logic erd, input logic ewr, input logic rdy,
                        input logic [9:0] ctl, input int cnt);
        exp_t e;
        @(posedge clk); #1;
        reset = rst; idex_MemRead = mr; idex_rt = irt; ifid_rs = rs; ifid_rt = rt;
        ifid_uses_rt = urt; branch_taken = br; jump_id = jp;
        exmem_MemRead = erd; exmem_MemWrite = ewr; dmem_ready = rdy;
        e.name = name; e.ctl = ctl; e.cnt = CNT_W'(cnt);
        q.push_back(e);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++)
            step("reset_hold", 1, 0,0,0,0,0, 0,0, 0,0,0, E_RESET, 0);
        step("rst_flush",  0, 0,0,0,0,0, 0,0, 0,0,0, E_FLUSH, 0);
        step("run_idle",   0, 0,0,0,0,0, 0,0, 0,0,0, E_RUN,   0);
        step("load_use",   0, 1,8,8,0,0, 0,0, 0,0,0, E_LU,    0);
        step("lu_one",     0, 0,0,0,0,0, 0,0, 0,0,0, E_RUN,   1);
        step("lu_r0",      0, 1,0,0,0,1, 0,0, 0,0,0, E_RUN,   1);
        step("br_over_lu", 0, 1,9,3,9,1, 1,0, 0,0,0, E_BR,    1);
        step("jump",       0, 0,0,0,0,0, 0,1, 0,0,0, E_JMP,   1);
        step("ld_wait1",   0, 0,0,0,0,0, 0,0, 1,0,0, E_FRZ,   1);
        step("ld_wait2",   0, 0,0,0,0,0, 1,0, 1,0,0, E_FRZ,   2);
        step("ld_wait3",   0, 1,4,4,0,0, 0,1, 1,0,0, E_FRZ,   3);
        step("ld_ready",   0, 0,0,0,0,0, 0,0, 1,0,1, E_MEMOK, 4);
        step("after_ld",   0, 0,0,0,0,0, 0,0, 0,0,0, E_RUN,   4);
        step("zero_wait",  0, 0,0,0,0,0, 0,0, 1,0,1, E_MEMOK, 4);
        step("st_run",     0, 0,0,0,0,0, 0,0, 0,1,0, E_FRZ,   4);
        step("st_w1",      0, 0,0,0,0,0, 0,0, 0,1,0, E_FRZ,   5);
        step("st_w2",      0, 0,0,0,0,0, 0,0, 0,1,0, E_FRZ,   6);
        step("st_w3_sat",  0, 0,0,0,0,0, 0,0, 0,1,0, E_FRZ,   7);
        step("st_w4_sat",  0, 0,0,0,0,0, 0,0, 0,1,0, E_FRZ,   7);
        step("halt",       0, 0,0,0,0,0, 0,0, 0,1,0, E_HALT,  7);
        step("halt_stick", 0, 0,0,0,0,0, 0,0, 0,0,1, E_HALT,  7);
        step("halt_rst",   1, 0,0,0,0,0, 0,0, 0,0,0, E_RESET, 7);
        step("rst_flush2", 0, 0,0,0,0,0, 0,0, 0,0,0, E_FLUSH, 0);
        step("run2",       0, 0,0,0,0,0, 0,0, 0,0,0, E_RUN,   0);
        step("ld2_run",    0, 0,0,0,0,0, 0,0, 1,0,0, E_FRZ,   0);
        step("ld2_w1",     0, 0,0,0,0,0, 0,0, 1,0,0, E_FRZ,   1);
        step("ld2_w2_rst", 1, 0,0,0,0,0, 0,0, 1,0,0, E_RESET, 2);
        step("rst_flush3", 0, 0,0,0,0,0, 0,0, 1,0,0, E_FLUSH, 0);
        step("run3",       0, 0,0,0,0,0, 0,0, 0,0,0, E_RUN,   0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
